// File: rtl/bcd_serial_adder_pkg.sv
// Shared types and constants for the serial BCD adder.
// Used by bcd_digit_add and by the bcd_serial_adder top level.
package bcd_serial_adder_pkg;

    localparam int BCD_DIGIT_W = 4;

    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX  = 4'd9;
    localparam logic [BCD_DIGIT_W-1:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic bcd_valid(input logic [BCD_DIGIT_W-1:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_adder_digit_add.sv
// Single-digit decimal adder: binary add, then +6 correction when the raw sum exceeds 9.
// Out-of-range inputs still go through the same arithmetic; they are only flagged.
module bcd_digit_add
    import bcd_serial_adder_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a_i,
    input  logic [BCD_DIGIT_W-1:0] b_i,
    input  logic                   c_i,
    output logic [BCD_DIGIT_W-1:0] s_o,
    output logic                   c_o,
    output logic                   inv_o
);

    logic [BCD_DIGIT_W:0] raw;

    always_comb begin
        raw   = {1'b0, a_i} + {1'b0, b_i} + {{BCD_DIGIT_W{1'b0}}, c_i};
        c_o   = raw > {1'b0, BCD_MAX};
        // Dropping bit 4 after the +6 is exactly the decimal wrap for raw 10..19.
        s_o   = c_o ? (raw[BCD_DIGIT_W-1:0] + BCD_CORR) : raw[BCD_DIGIT_W-1:0];
        inv_o = !bcd_valid(a_i) || !bcd_valid(b_i);
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder, one digit per clock, LSD first; done pulses one cycle after the last digit.
// Define BCD_SUB_EN to add the sub port (nine's-complement subtract with forced carry-in).
module bcd_serial_adder
    import bcd_serial_adder_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    input  logic                          cin,
`ifdef BCD_SUB_EN
    input  logic                          sub,
`endif
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
    output logic                          cout,
    output logic                          err
);

    localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);

    state_t state_q, state_d;

    logic [DIGITS-1:0][BCD_DIGIT_W-1:0] a_q, b_q, sum_q;
    logic [IDX_W-1:0]                   idx_q;
    logic                               carry_q, cout_q, err_q;

    logic                   accept, run, last;
    logic                   init_carry;
    logic [BCD_DIGIT_W-1:0] a_dig, b_dig, d_sum;
    logic                   d_carry, d_inv;

    assign accept = (state_q == IDLE) && start;
    assign run    = (state_q == RUN);
    assign last   = (idx_q == LAST_IDX);
    assign a_dig  = a_q[idx_q];

`ifdef BCD_SUB_EN
    logic sub_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         sub_q <= 1'b0;
        else if (accept) sub_q <= sub;
    end

    // A - B == A + (nine's complement of B) + 1; cin plays no part in a subtract.
    assign init_carry = sub | cin;
    assign b_dig      = sub_q ? (BCD_MAX - b_q[idx_q]) : b_q[idx_q];
`else
    assign init_carry = cin;
    assign b_dig      = b_q[idx_q];
`endif

    bcd_digit_add u_digit (
        .a_i   (a_dig),
        .b_i   (b_dig),
        .c_i   (carry_q),
        .s_o   (d_sum),
        .c_o   (d_carry),
        .inv_o (d_inv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= init_carry;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (run) begin
            sum_q[idx_q] <= d_sum;
            carry_q      <= d_carry;
            err_q        <= err_q | d_inv;
            // cout is captured with the last digit so it is already valid in DONE.
            if (last) cout_q <= d_carry;
            else      idx_q  <= idx_q + IDX_W'(1);
        end
    end

    assign busy = run;
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder (DIGITS=4); sub tests run only with BCD_SUB_EN.
module tb_bcd_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s = 1'b0;
    logic [15:0] a_s = '0;
    logic [15:0] b_s = '0;
    logic        cin_s = 1'b0;
`ifdef BCD_SUB_EN
    logic        sub_s = 1'b0;
`endif
    logic        busy, done, cout, err;
    logic [15:0] sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .a     (a_s),
        .b     (b_s),
        .cin   (cin_s),
`ifdef BCD_SUB_EN
        .sub   (sub_s),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    // Pulses start for one cycle; lat is the number of negedges until done (-1 on timeout).
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                          output int lat);
        @(negedge clk);
        a_s = ta; b_s = tb_; cin_s = tc; start_s = 1'b1;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start_s = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int lat;
        start_s = 1'b1;
        a_s = 16'h0042; b_s = 16'h0058;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, cout, err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, cout, err});
        end
        n_checks++;
        if (sum !== 16'h0000) begin
            n_fail++; $display("FAIL reset_sum: got %h expected 0000", sum);
        end
        // Start already high: must be taken on the first edge after release.
        rst = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start_s = 1'b0;
            if (done) begin lat = n; break; end
        end
        n_checks++;
        if (lat !== 5) begin
            n_fail++; $display("FAIL reset_first_start_lat: got %0d expected 5", lat);
        end
        n_checks++;
        if (sum !== 16'h0100 || cout !== 1'b0) begin
            n_fail++; $display("FAIL reset_first_start_sum: got %h/%b expected 0100/0", sum, cout);
        end
    endtask

    task automatic test_basic_add();
        int busy_cnt = 0;
        int done_at  = -1;
        @(negedge clk);
        a_s = 16'h1234; b_s = 16'h5678; cin_s = 1'b0; start_s = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            start_s = 1'b0;
            if (busy) busy_cnt++;
            if (done && done_at < 0) done_at = n;
        end
        n_checks++;
        if (done_at !== 5) begin
            n_fail++; $display("FAIL basic_latency: got %0d expected 5", done_at);
        end
        n_checks++;
        if (busy_cnt !== 4) begin
            n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 4", busy_cnt);
        end
        n_checks++;
        if (sum !== 16'h6912 || cout !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL basic_result: got %h/%b/%b expected 6912/0/0", sum, cout, err);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || sum !== 16'h6912) begin
            n_fail++; $display("FAIL basic_done_pulse_hold: got done=%b sum=%h expected 0/6912", done, sum);
        end
    endtask

    task automatic test_carry();
        int lat;
        logic [15:0] va [4] = '{16'h9999, 16'h0000, 16'h5555, 16'h9999};
        logic [15:0] vb [4] = '{16'h0001, 16'h0000, 16'h4445, 16'h9999};
        logic        vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] es [4] = '{16'h0000, 16'h0001, 16'h0000, 16'h9999};
        logic        ec [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], lat);
            n_checks++;
            if (lat !== 5 || sum !== es[i] || cout !== ec[i]) begin
                n_fail++;
                $display("FAIL carry_vec%0d: got lat=%0d sum=%h cout=%b expected 5/%h/%b",
                         i, lat, sum, cout, es[i], ec[i]);
            end
        end
    endtask

    task automatic test_err();
        int lat;
        run_op(16'h000A, 16'h0000, 1'b0, lat);
        n_checks++;
        if (err !== 1'b1 || sum !== 16'h0010 || cout !== 1'b0) begin
            n_fail++; $display("FAIL err_low_digit: got %b/%h/%b expected 1/0010/0", err, sum, cout);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got %b expected 1", err);
        end
        run_op(16'h0000, 16'hF000, 1'b0, lat);
        n_checks++;
        if (err !== 1'b1 || sum !== 16'h5000 || cout !== 1'b1) begin
            n_fail++; $display("FAIL err_high_digit: got %b/%h/%b expected 1/5000/1", err, sum, cout);
        end
        @(negedge clk);
        a_s = 16'h0011; b_s = 16'h0022; cin_s = 1'b0; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        n_checks++;
        if (err !== 1'b0 || sum !== 16'h0000) begin
            n_fail++; $display("FAIL err_clear_on_start: got %b/%h expected 0/0000", err, sum);
        end
        lat = -1;
        for (int n = 2; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin lat = n; break; end
        end
        n_checks++;
        if (lat !== 5 || err !== 1'b0 || sum !== 16'h0033) begin
            n_fail++; $display("FAIL err_clean_op: got lat=%0d err=%b sum=%h expected 5/0/0033", lat, err, sum);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        @(negedge clk);
        a_s = 16'h123A; b_s = 16'h5678; cin_s = 1'b0; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || err !== 1'b1 || sum !== 16'h0008) begin
            n_fail++; $display("FAIL midrun_pre: got busy=%b err=%b sum=%h expected 1/1/0008", busy, err, sum);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, cout, err} !== 4'b0000 || sum !== 16'h0000) begin
            n_fail++; $display("FAIL midrun_reset: got flags=%b sum=%h expected 0000/0000", {busy, done, cout, err}, sum);
        end
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || sum !== 16'h0000) begin
            n_fail++; $display("FAIL midrun_no_resume: got busy=%b sum=%h expected 0/0000", busy, sum);
        end
        run_op(16'h1234, 16'h5678, 1'b0, lat);
        n_checks++;
        if (lat !== 5 || sum !== 16'h6912 || cout !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL midrun_fresh: got lat=%0d %h/%b/%b expected 5/6912/0/0", lat, sum, cout, err);
        end
    endtask

    task automatic test_ignore_start();
        int done_at = -1;
        @(negedge clk);
        a_s = 16'h1111; b_s = 16'h2222; cin_s = 1'b0; start_s = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            start_s = (n == 2);
            if (n >= 1) begin a_s = 16'h9999; b_s = 16'h9999; cin_s = 1'b1; end
            if (done) begin done_at = n; break; end
        end
        start_s = 1'b0;
        n_checks++;
        if (done_at !== 5 || sum !== 16'h3333 || cout !== 1'b0) begin
            n_fail++; $display("FAIL ignore_start: got lat=%0d sum=%h cout=%b expected 5/3333/0", done_at, sum, cout);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || sum !== 16'h3333) begin
            n_fail++; $display("FAIL ignore_start_idle: got busy=%b sum=%h expected 0/3333", busy, sum);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s5, s7, s11;
        logic d5, d6, b6, b7, d11, c11;
        @(negedge clk);
        a_s = 16'h1234; b_s = 16'h5678; cin_s = 1'b0; start_s = 1'b1;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (n == 1) begin a_s = 16'h4321; b_s = 16'h1111; end
            if (n == 5)  begin d5 = done; s5 = sum; end
            if (n == 6)  begin d6 = done; b6 = busy; end
            if (n == 7)  begin b7 = busy; s7 = sum; end
            if (n == 11) begin d11 = done; s11 = sum; c11 = cout; end
        end
        start_s = 1'b0;
        n_checks++;
        if (d5 !== 1'b1 || s5 !== 16'h6912) begin
            n_fail++; $display("FAIL b2b_first: got done=%b sum=%h expected 1/6912", d5, s5);
        end
        n_checks++;
        if (d6 !== 1'b0 || b6 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle_gap: got done=%b busy=%b expected 0/0", d6, b6);
        end
        n_checks++;
        if (b7 !== 1'b1 || s7 !== 16'h0000) begin
            n_fail++; $display("FAIL b2b_relaunch: got busy=%b sum=%h expected 1/0000", b7, s7);
        end
        n_checks++;
        if (d11 !== 1'b1 || s11 !== 16'h5432 || c11 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second: got done=%b sum=%h cout=%b expected 1/5432/0", d11, s11, c11);
        end
        repeat (8) @(negedge clk);
    endtask

`ifdef BCD_SUB_EN
    task automatic test_sub();
        int lat;
        sub_s = 1'b1;
        run_op(16'h5000, 16'h1234, 1'b0, lat);
        n_checks++;
        if (lat !== 5 || sum !== 16'h3766 || cout !== 1'b1) begin
            n_fail++; $display("FAIL sub_pos: got lat=%0d sum=%h cout=%b expected 5/3766/1", lat, sum, cout);
        end
        run_op(16'h0123, 16'h0456, 1'b1, lat);
        n_checks++;
        if (lat !== 5 || sum !== 16'h9667 || cout !== 1'b0) begin
            n_fail++; $display("FAIL sub_neg: got lat=%0d sum=%h cout=%b expected 5/9667/0", lat, sum, cout);
        end
        sub_s = 1'b0;
        run_op(16'h5000, 16'h1234, 1'b0, lat);
        n_checks++;
        if (sum !== 16'h6234 || cout !== 1'b0) begin
            n_fail++; $display("FAIL sub_off_add: got sum=%h cout=%b expected 6234/0", sum, cout);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_add();
        test_carry();
        test_err();
        test_reset_mid_run();
        test_ignore_start();
        test_back_to_back();
`ifdef BCD_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 Parameter: DIGITS, default 4, number of BCD digits per operand (legal range 1..16).
REQ-002 clk  input  1  rising-edge clock for all sequential logic.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 a  input  4*DIGITS  BCD operand A; digit 0 is in bits [3:0].
REQ-006 b  input  4*DIGITS  BCD operand B, same digit layout as a.
REQ-007 cin  input  1  decimal carry-in for addition.
REQ-008 sub  input  1  1 = A minus B; port exists only when BCD_SUB_EN is defined.
REQ-009 busy  output  1  high while digits are being processed.
REQ-010 done  output  1  single-cycle pulse when sum and cout are valid.
REQ-011 sum  output  4*DIGITS  BCD result, held stable until the next accepted start.
REQ-012 cout  output  1  final decimal carry-out.
REQ-013 err  output  1  at least one latched operand digit was greater than 9.

Function
REQ-014 States: IDLE, RUN, DONE. Encoding is free.
REQ-015 IDLE with start=1: latch a, b, cin (and sub); set digit index to 0; clear sum and err; go to RUN.
REQ-016 RUN, one digit per cycle, least-significant digit first: digit sum = a_i + b_i + carry; if the raw sum > 9, add 6 and set carry=1, else carry=0; write the result to sum digit i.
REQ-017 RUN: after digit DIGITS-1 is written, go to DONE. Otherwise increment the index and stay in RUN.
REQ-018 DONE: done=1 for exactly one cycle; cout = final carry; next state is IDLE.
REQ-019 Latency: start sampled at edge T gives done=1 in the cycle after edge T+DIGITS; busy=1 for exactly DIGITS cycles.
REQ-020 start is ignored in RUN and DONE, and operands may change freely after latching without affecting the result.
REQ-021 err is set in the cycle a digit greater than 9 is processed and stays set until the next accepted start. The arithmetic of REQ-016 is still applied to that digit.
REQ-022 A start asserted continuously re-launches in the IDLE cycle that follows DONE.

Reset
REQ-023 rst=1 forces IDLE immediately. busy, done, cout and err go to 0, sum goes to 0, and the carry and index registers clear, including mid-RUN. No partial result survives.
REQ-024 The first start is accepted on the first rising edge after rst deasserts.

Configuration
REQ-025 Macro BCD_SUB_EN: when defined, the sub port exists. With sub=1, each b digit is replaced by its nine's complement (9-b_i), the initial carry is forced to 1, and cin is ignored. cout=1 means a non-negative result; cout=0 means a ten's-complement negative result.
REQ-026 Without BCD_SUB_EN: no sub port and no complement logic; the block is an adder only.

Structure
REQ-027 A shared package holds the state enum type, BCD_DIGIT_W=4, BCD_MAX=9 and BCD_CORR=6.
REQ-028 One combinational sub-module, bcd_digit_add, takes a 4-bit digit, a 4-bit digit and a 1-bit carry-in, and produces a 4-bit sum, a 1-bit carry-out and a 1-bit invalid flag.
REQ-029 The top level contains only the FSM, operand and result registers, the index counter, and the optional complement logic.

Verification (DIGITS=4)
REQ-030 a=1234, b=5678, cin=0, start -> sum=6912, cout=0, err=0; done arrives 5 cycles after start.
REQ-031 a=9999, b=0001, cin=0 -> sum=0000, cout=1. Separately, a=0000, b=0000, cin=1 -> sum=0001, cout=0.
REQ-032 With BCD_SUB_EN: 5000-1234 -> sum=3766, cout=1. 0123-0456 -> sum=9667, cout=0.
REQ-033 a digit 0 = 0xA, b=0000 -> err=1 at done. The next valid start clears err.
REQ-034 rst pulsed during the second RUN cycle -> busy=0, done=0, sum=0000, cout=0 immediately; a fresh operation then gives correct results.
REQ-035 start re-pulsed with new operands while busy -> ignored; the result matches the first operands.
